// File: rtl/branch_predictor_bht.sv
// Tagged, direct-mapped branch history / target table.
// Lookup is combinational from the fetch PC; resolved branches from the
// decode-stage compare train the table one cycle later. Optional gshare
// indexing folds the global history into the index. Two saturating
// performance counters track resolved branches and mispredictions.
module branch_predictor_bht #(
  parameter int DATA_W  = 64,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int GSHARE  = 0,
  parameter int GHR_W   = 6,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              clr,
  input  logic [DATA_W-1:0] if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [DATA_W-1:0] pred_target,
  output logic [GHR_W-1:0]  pred_ghr,
  input  logic              upd_valid,
  input  logic [DATA_W-1:0] upd_pc,
  input  logic [GHR_W-1:0]  upd_ghr,
  input  logic              upd_taken,
  input  logic [DATA_W-1:0] upd_target,
  input  logic              upd_mispred,
  output logic [CNT_W-1:0]  n_branches,
  output logic [CNT_W-1:0]  n_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  // Storage width for tags; an untagged table keeps a 1-bit dummy that is
  // never compared.
  localparam int TAG_SW = (TAG_W > 0) ? TAG_W : 1;

  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Table storage
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_SW-1:0]  tag_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q [ENTRIES];
  logic [DATA_W-1:0]  tgt_q [ENTRIES];
  logic [GHR_W-1:0]   ghr_q;

  // Word-aligned PC bits select the entry; gshare folds history in.
  function automatic logic [IDX_W-1:0] calc_idx(input logic [DATA_W-1:0] pc,
                                                input logic [GHR_W-1:0]  ghr);
    logic [IDX_W-1:0] idx;
    idx = pc[IDX_W+1:2];
    if (GSHARE != 0) idx = idx ^ IDX_W'(ghr);
    return idx;
  endfunction

  // Tag is the PC slice directly above the index bits.
  function automatic logic [TAG_SW-1:0] calc_tag(input logic [DATA_W-1:0] pc);
    return TAG_SW'(pc >> (IDX_W + 2));
  endfunction

  // ---------------------------------------------------------------------
  // Lookup path: reads the registered table only, so a same-cycle update
  // to the same entry is not bypassed.
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_SW-1:0] lk_tag;
  logic              lk_tag_ok;

  assign lk_idx      = calc_idx(if_pc, ghr_q);
  assign lk_tag      = calc_tag(if_pc);
  assign lk_tag_ok   = (TAG_W == 0) || (tag_q[lk_idx] == lk_tag);
  assign pred_hit    = valid_q[lk_idx] && lk_tag_ok;
  assign pred_taken  = pred_hit && ctr_q[lk_idx][CTR_W-1];
  assign pred_target = pred_taken ? tgt_q[lk_idx] : (if_pc + DATA_W'(4));
  assign pred_ghr    = ghr_q;

  // ---------------------------------------------------------------------
  // Update path: indexed with the history captured at prediction time.
  // ---------------------------------------------------------------------
  logic              upd_en;
  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_SW-1:0] upd_tag;
  logic              upd_hit;
  logic [CTR_W-1:0]  ctr_cur;
  logic [CTR_W-1:0]  ctr_nxt;
  logic [GHR_W-1:0]  ghr_nxt;

  assign upd_en  = upd_valid && enable;
  assign upd_idx = calc_idx(upd_pc, upd_ghr);
  assign upd_tag = calc_tag(upd_pc);
  assign upd_hit = valid_q[upd_idx] && ((TAG_W == 0) || (tag_q[upd_idx] == upd_tag));
  assign ctr_cur = ctr_q[upd_idx];
  // Shift form stays legal for a 1-bit history.
  assign ghr_nxt = (ghr_q << 1) | GHR_W'(upd_taken);

  // Saturating counter step toward the resolved direction
  always_comb begin
    // NOTE: default first so every path assigns ctr_nxt; otherwise a latch is inferred.
    ctr_nxt = ctr_cur;
    if (upd_taken) begin
      if (ctr_cur != CTR_MAX) ctr_nxt = ctr_cur + CTR_W'(1);
    end else begin
      if (ctr_cur != '0) ctr_nxt = ctr_cur - CTR_W'(1);
    end
  end

  // Table write: clear beats update; clear drops valid bits only
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      // NOTE: the table is reset entry by entry because defined counters and
      // targets are part of the reset state; this keeps it in flops, not RAM.
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        ctr_q[i] <= CTR_WNT;
        tgt_q[i] <= '0;
      end
    end else if (clr) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // read in this block sees the pre-edge value.
      valid_q <= '0;
    end else if (upd_en) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_nxt;
        if (upd_taken) tgt_q[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= upd_tag;
        tgt_q[upd_idx]   <= upd_target;
        ctr_q[upd_idx]   <= CTR_WT;
      end
    end
  end

  // Global history: shifts in each accepted outcome, cleared by clr
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ghr_q <= '0;
    end else if (clr) begin
      ghr_q <= '0;
    end else if (upd_en) begin
      ghr_q <= ghr_nxt;
    end
  end

  // Performance counters: saturate at all-ones, survive clr
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      n_branches <= '0;
      n_mispred  <= '0;
    end else if (upd_en && !clr) begin
      if (n_branches != CNT_MAX) n_branches <= n_branches + CNT_W'(1);
      if (upd_mispred && (n_mispred != CNT_MAX)) n_mispred <= n_mispred + CNT_W'(1);
    end
  end

  // Low PC bits carry no index or tag information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench: a bimodal instance (small perf counters) and a gshare
// instance share one stimulus stream; each step checks hand-computed values.
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        enable = 1'b0;
  logic        clr = 1'b0;
  logic [63:0] if_pc = '0;
  logic        upd_valid = 1'b0;
  logic [63:0] upd_pc = '0;
  logic [5:0]  upd_ghr = '0;
  logic        upd_taken = 1'b0;
  logic [63:0] upd_target = '0;
  logic        upd_mispred = 1'b0;

  logic        b_hit, b_taken, g_hit, g_taken;
  logic [63:0] b_target, g_target;
  logic [5:0]  b_ghr, g_ghr;
  logic [3:0]  b_nbr, b_nmp;
  logic [31:0] g_nbr, g_nmp;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_br   = 0;
  int exp_mp   = 0;

  branch_predictor_bht #(.GSHARE(0), .CNT_W(4)) u_bim (
    .clk(clk), .arst_n(arst_n), .enable(enable), .clr(clr), .if_pc(if_pc),
    .pred_hit(b_hit), .pred_taken(b_taken), .pred_target(b_target), .pred_ghr(b_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred),
    .n_branches(b_nbr), .n_mispred(b_nmp)
  );

  branch_predictor_bht #(.GSHARE(1)) u_gs (
    .clk(clk), .arst_n(arst_n), .enable(enable), .clr(clr), .if_pc(if_pc),
    .pred_hit(g_hit), .pred_taken(g_taken), .pred_target(g_target), .pred_ghr(g_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred),
    .n_branches(g_nbr), .n_mispred(g_nmp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one resolved branch and advance the small perf-counter model.
  task automatic upd_drive(input logic [63:0] pc, input logic [5:0] ghr, input logic t,
                           input logic [63:0] tgt, input logic mp);
    upd_valid   = 1'b1;
    upd_pc      = pc;
    upd_ghr     = ghr;
    upd_taken   = t;
    upd_target  = tgt;
    upd_mispred = mp;
    if (enable && !clr) begin
      if (exp_br != 15) exp_br++;
      if (mp && exp_mp != 15) exp_mp++;
    end
  endtask

  task automatic upd_idle();
    upd_valid   = 1'b0;
    upd_taken   = 1'b0;
    upd_mispred = 1'b0;
    upd_target  = '0;
  endtask

  task automatic upd(input logic [63:0] pc, input logic [5:0] ghr, input logic t,
                     input logic [63:0] tgt, input logic mp);
    upd_drive(pc, ghr, t, tgt, mp);
    tick();
    upd_idle();
  endtask

  // Lookup check on either instance (gs=1 selects the gshare one).
  task automatic look(input string tag, input logic gs, input logic [63:0] pc,
                      input logic hit, input logic taken, input logic [63:0] tgt);
    if_pc = pc;
    #1;
    check({tag, ".hit"},    gs ? 64'(g_hit)   : 64'(b_hit),   64'(hit));
    check({tag, ".taken"},  gs ? 64'(g_taken) : 64'(b_taken), 64'(taken));
    check({tag, ".target"}, gs ? g_target     : b_target,     tgt);
  endtask

  initial begin
    // Reset
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #3 arst_n = 1'b1;
    tick();
    look("reset", 1'b0, 64'h100, 1'b0, 1'b0, 64'h104);
    check("reset.n_branches", 64'(b_nbr), 64'd0);
    check("reset.n_mispred",  64'(b_nmp), 64'd0);
    check("reset.ghr",        64'(g_ghr), 64'd0);

    // Allocate; lookup in the same cycle still sees the old entry
    upd_drive(64'h100, 6'h0, 1'b1, 64'h80, 1'b1);
    if_pc = 64'h100;
    #1;
    check("same_cycle.hit", 64'(b_hit), 64'd0);
    tick();
    upd_idle();
    look("alloc", 1'b0, 64'h100, 1'b1, 1'b1, 64'h80);
    check("alloc.n_branches", 64'(b_nbr), 64'(exp_br));

    // Saturate up, then walk down: 3 -> 2 (taken) -> 1 (not taken)
    repeat (4) upd(64'h100, 6'h0, 1'b1, 64'h80, 1'b0);
    look("sat_hi", 1'b0, 64'h100, 1'b1, 1'b1, 64'h80);
    upd(64'h100, 6'h0, 1'b0, 64'hDEAD, 1'b1);
    look("nt1", 1'b0, 64'h100, 1'b1, 1'b1, 64'h80);
    upd(64'h100, 6'h0, 1'b0, 64'hDEAD, 1'b0);
    look("nt2", 1'b0, 64'h100, 1'b1, 1'b0, 64'h104);
    // Saturate low at 0, then two taken to climb back to weakly taken
    repeat (3) upd(64'h100, 6'h0, 1'b0, 64'hDEAD, 1'b0);
    upd(64'h100, 6'h0, 1'b1, 64'h80, 1'b1);
    look("sat_lo_t1", 1'b0, 64'h100, 1'b1, 1'b0, 64'h104);
    upd(64'h100, 6'h0, 1'b1, 64'h80, 1'b0);
    look("sat_lo_t2", 1'b0, 64'h100, 1'b1, 1'b1, 64'h80);
    check("train.n_branches", 64'(b_nbr), 64'(exp_br));
    check("train.n_mispred",  64'(b_nmp), 64'(exp_mp));

    // Aliasing: same index, different tag
    look("alias_miss", 1'b0, 64'h200, 1'b0, 1'b0, 64'h204);
    upd(64'h200, 6'h0, 1'b1, 64'h300, 1'b1);
    look("alias_new", 1'b0, 64'h200, 1'b1, 1'b1, 64'h300);
    look("alias_old", 1'b0, 64'h100, 1'b0, 1'b0, 64'h104);
    upd(64'h500, 6'h0, 1'b0, 64'hBAD, 1'b0);
    look("miss_nt_nowrite", 1'b0, 64'h200, 1'b1, 1'b1, 64'h300);

    // Stall: update ignored, counters frozen
    enable = 1'b0;
    upd(64'h200, 6'h0, 1'b0, 64'hBAD, 1'b1);
    enable = 1'b1;
    look("stall", 1'b0, 64'h200, 1'b1, 1'b1, 64'h300);
    check("stall.n_branches", 64'(b_nbr), 64'(exp_br));
    check("stall.n_mispred",  64'(b_nmp), 64'(exp_mp));

    // Clear with a concurrent taken update: nothing allocated
    clr = 1'b1;
    upd(64'h100, 6'h0, 1'b1, 64'h40, 1'b0);
    clr = 1'b0;
    look("clr_a", 1'b0, 64'h100, 1'b0, 1'b0, 64'h104);
    look("clr_b", 1'b0, 64'h200, 1'b0, 1'b0, 64'h204);
    check("clr.ghr", 64'(g_ghr), 64'd0);

    // Perf counters saturate at all-ones
    repeat (14) upd(64'h500, 6'h0, 1'b0, 64'h0, 1'b1);
    check("sat.n_branches", 64'(b_nbr), 64'hF);
    check("sat.n_mispred",  64'(b_nmp), 64'hF);
    upd(64'h500, 6'h0, 1'b0, 64'h0, 1'b1);
    check("sat_hold.n_mispred", 64'(b_nmp), 64'hF);

    // Gshare: same PC, histories 0 and 3F train separate entries
    clr = 1'b1;
    tick();
    clr = 1'b0;
    upd(64'h100, 6'h00, 1'b1, 64'h80, 1'b0);
    upd(64'h100, 6'h3F, 1'b1, 64'h90, 1'b0);
    upd(64'h100, 6'h00, 1'b0, 64'hBAD, 1'b1);
    upd(64'h100, 6'h00, 1'b0, 64'hBAD, 1'b1);
    upd(64'h100, 6'h3F, 1'b1, 64'h90, 1'b0);
    // history shifted in T,T,N,N,T
    check("gs.ghr_shift", 64'(g_ghr), 64'h19);
    look("gs_ghr19", 1'b1, 64'h100, 1'b0, 1'b0, 64'h104);
    repeat (6) upd(64'h500, 6'h00, 1'b0, 64'h0, 1'b0);
    check("gs.ghr_zero", 64'(g_ghr), 64'h00);
    look("gs_ghr00", 1'b1, 64'h100, 1'b1, 1'b0, 64'h104);
    repeat (6) upd(64'h504, 6'h00, 1'b1, 64'h600, 1'b0);
    check("gs.ghr_ones", 64'(g_ghr), 64'h3F);
    look("gs_ghr3f", 1'b1, 64'h100, 1'b1, 1'b1, 64'h90);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
